// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
//
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring divide) over
// WIDTH iteration cycles plus one sign-fix cycle. MFHI/MFLO/MTHI/MTLO complete
// in a single cycle.
//
// Build option: define MIPS_MULDIV_DIV_EN to compile in the divider. When it is
// undefined, DIV/DIVU are answered like an illegal funct (1-cycle done + err).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request valid, sampled only while idle
//   funct[5:0]      R-type funct code
//   a, b            rs / rt operands
//   busy            iterative operation in progress
//   done, err       one-cycle completion pulse and its error qualifier
//   result          MFHI/MFLO read data, held until the next MF op
//   hi, lo          architectural HI/LO registers

module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // Multiply: acc_hi = partial product upper half, acc_lo = multiplier
    // shifting out while product low bits shift in; opnd = multiplicand.
    // Divide:   acc_hi = partial remainder, acc_lo = dividend shifting out
    // while quotient bits shift in; opnd = divisor.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             neg_lo;   // negate product / quotient in FIX
    logic             neg_hi;   // negate product / remainder in FIX
    logic             op_div;

    // Operand conditioning for signed ops: magnitudes plus sign flags.
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign a_neg     = signed_op && a[WIDTH-1];
    assign b_neg     = signed_op && b[WIDTH-1];
    assign a_abs     = a_neg ? -a : a;
    assign b_abs     = b_neg ? -b : b;

    // One shift-add step; the carry out of the add becomes the new top bit.
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

`ifdef MIPS_MULDIV_DIV_EN
    // One restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
`endif

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_hi ? -prod : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            op_div <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (funct)
                            F_MFHI: begin
                                result <= hi;
                                done   <= 1'b1;
                            end
                            F_MFLO: begin
                                result <= lo;
                                done   <= 1'b1;
                            end
                            F_MTHI: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            F_MTLO: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            F_MULT, F_MULTU: begin
                                acc_hi <= '0;
                                acc_lo <= b_abs;
                                opnd   <= a_abs;
                                neg_lo <= a_neg ^ b_neg;
                                neg_hi <= a_neg ^ b_neg;
                                op_div <= 1'b0;
                                cnt    <= CW'(WIDTH - 1);
                                busy   <= 1'b1;
                                state  <= S_MUL;
                            end
`ifdef MIPS_MULDIV_DIV_EN
                            F_DIV, F_DIVU: begin
                                if (b == '0) begin
                                    done <= 1'b1;
                                    err  <= 1'b1;
                                end else begin
                                    acc_hi <= '0;
                                    acc_lo <= a_abs;
                                    opnd   <= b_abs;
                                    // Quotient sign from both operands,
                                    // remainder follows the dividend.
                                    neg_lo <= a_neg ^ b_neg;
                                    neg_hi <= a_neg;
                                    op_div <= 1'b1;
                                    cnt    <= CW'(WIDTH - 1);
                                    busy   <= 1'b1;
                                    state  <= S_DIV;
                                end
                            end
`endif
                            default: begin
                                done <= 1'b1;
                                err  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV: begin
`ifdef MIPS_MULDIV_DIV_EN
                    if (!div_diff[WIDTH]) begin
                        acc_hi <= div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
`else
                    busy  <= 1'b0;
                    state <= S_IDLE;
`endif
                end
                S_FIX: begin
                    if (op_div) begin
                        lo <= neg_lo ? -acc_lo : acc_lo;
                        hi <= neg_hi ? -acc_hi : acc_hi;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - self-checking bench for mips_muldiv_unit

module tb_mips_muldiv_unit;

`ifdef MIPS_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct  (funct),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request; returns edges from acceptance to done, and the
    // number of sampled cycles with busy high.
    task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; funct = f; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; funct = 6'($urandom); a = $urandom; b = $urandom;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        if (!done) chk("timeout", {63'd0, done}, 64'd1);
    endtask

    // Reference model: architectural effect of one op, from plain arithmetic.
    logic [31:0] m_hi, m_lo, m_res;
    logic        m_err;
    int          m_lat;

    task automatic model(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        m_err = 1'b0;
        m_lat = 0;
        case (f)
            6'h10: m_res = m_hi;
            6'h11: m_hi  = av;
            6'h12: m_res = m_lo;
            6'h13: m_lo  = av;
            6'h18: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; m_lat = 33; end
            6'h19: begin p = {32'd0, av} * {32'd0, bv}; m_hi = p[63:32]; m_lo = p[31:0]; m_lat = 33; end
            6'h1A: begin
                if (!DIV_EN || bv == 0) m_err = 1'b1;
                else begin
                    p = sa / sb; m_lo = p[31:0];
                    p = sa % sb; m_hi = p[31:0];
                    m_lat = 33;
                end
            end
            6'h1B: begin
                if (!DIV_EN || bv == 0) m_err = 1'b1;
                else begin m_lo = av / bv; m_hi = av % bv; m_lat = 33; end
            end
            default: m_err = 1'b1;
        endcase
    endtask

    typedef struct {
        string       nm;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tv[9];

    initial begin
        int lat, bcnt;
        logic [5:0] codes[9];

        tv[0] = '{"mult_m3x7",   6'h18, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 32'd0, 1'b0, 33};
        tv[1] = '{"multu_max",   6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'd0, 1'b0, 33};
`ifdef MIPS_MULDIV_DIV_EN
        tv[2] = '{"div_m7_2",    6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32'd0, 1'b0, 33};
        tv[3] = '{"divu_7_2",    6'h1B, 32'd7,        32'd2,        32'd1,        32'd3,        32'd0, 1'b0, 33};
        tv[4] = '{"div_ovf",     6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 32'd0, 1'b0, 33};
        tv[5] = '{"div_by_0",    6'h1A, 32'd5,        32'd0,        32'd0,        32'h80000000, 32'd0, 1'b1, 0};
        tv[6] = '{"mthi",        6'h11, 32'h1234,     32'd0,        32'h1234,     32'h80000000, 32'd0, 1'b0, 0};
        tv[7] = '{"mfhi",        6'h10, 32'd0,        32'd0,        32'h1234,     32'h80000000, 32'h1234, 1'b0, 0};
        tv[8] = '{"illegal_20",  6'h20, 32'd9,        32'd9,        32'h1234,     32'h80000000, 32'h1234, 1'b1, 0};
`else
        tv[2] = '{"div_m7_2",    6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFE, 32'h00000001, 32'd0, 1'b1, 0};
        tv[3] = '{"divu_7_2",    6'h1B, 32'd7,        32'd2,        32'hFFFFFFFE, 32'h00000001, 32'd0, 1'b1, 0};
        tv[4] = '{"div_ovf",     6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'd0, 1'b1, 0};
        tv[5] = '{"div_by_0",    6'h1A, 32'd5,        32'd0,        32'hFFFFFFFE, 32'h00000001, 32'd0, 1'b1, 0};
        tv[6] = '{"mthi",        6'h11, 32'h1234,     32'd0,        32'h1234,     32'h00000001, 32'd0, 1'b0, 0};
        tv[7] = '{"mfhi",        6'h10, 32'd0,        32'd0,        32'h1234,     32'h00000001, 32'h1234, 1'b0, 0};
        tv[8] = '{"illegal_20",  6'h20, 32'd9,        32'd9,        32'h1234,     32'h00000001, 32'h1234, 1'b1, 0};
`endif

        rst_n = 1'b0; start = 1'b0; funct = 6'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            issue(tv[i].f, tv[i].a, tv[i].b, lat, bcnt);
            chk({tv[i].nm, "_hi"}, {32'd0, hi}, {32'd0, tv[i].hi});
            chk({tv[i].nm, "_lo"}, {32'd0, lo}, {32'd0, tv[i].lo});
            chk({tv[i].nm, "_res"}, {32'd0, result}, {32'd0, tv[i].res});
            chk({tv[i].nm, "_err"}, {63'd0, err}, {63'd0, tv[i].err});
            chk({tv[i].nm, "_lat"}, 64'(lat), 64'(tv[i].lat));
            chk({tv[i].nm, "_busy_cycles"}, 64'(bcnt), 64'(tv[i].lat));
            @(negedge clk);
            chk({tv[i].nm, "_done_pulse"}, {62'd0, done, err}, 64'd0);
        end

        // MULT 2x3 with a second start mid-operation that must be ignored
        @(negedge clk);
        start = 1'b1; funct = 6'h18; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; funct = 6'h13; a = 32'd99; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        lat = 6;
        while (!done && lat < 200) begin @(negedge clk); lat++; end
        chk("midstart_lat", 64'(lat), 64'd33);
        chk("midstart_lo", {32'd0, lo}, 64'd6);
        chk("midstart_hi", {32'd0, hi}, 64'd0);
        @(negedge clk);
        chk("midstart_idle", {62'd0, busy, done}, 64'd0);

        // Reset after iteration edge 10 of a MULT
        @(negedge clk);
        start = 1'b1; funct = 6'h18; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {busy, done, err, 29'd0, result}, 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(6'h19, 32'd4, 32'd5, lat, bcnt);
        chk("post_rst_lo", {32'd0, lo}, 64'd20);
        chk("post_rst_hi", {32'd0, hi}, 64'd0);
        chk("post_rst_lat", 64'(lat), 64'd33);

        // Randomised ops against the reference model
        m_hi = 32'd0; m_lo = 32'd20; m_res = 32'd0;
        codes = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00};
        for (int i = 0; i < 60; i++) begin
            logic [5:0]  f;
            logic [31:0] av, bv;
            f  = codes[$urandom_range(0, 8)];
            if (f == 6'h00) f = 6'($urandom_range(32, 63));
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 7))
                0: bv = 32'd0;
                1: bv = 32'hFFFFFFFF;
                2: av = 32'h80000000;
                3: bv = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(f, av, bv);
            issue(f, av, bv, lat, bcnt);
            chk($sformatf("rnd%0d_f%h_hi", i, f), {32'd0, hi}, {32'd0, m_hi});
            chk($sformatf("rnd%0d_f%h_lo", i, f), {32'd0, lo}, {32'd0, m_lo});
            chk($sformatf("rnd%0d_f%h_res", i, f), {32'd0, result}, {32'd0, m_res});
            chk($sformatf("rnd%0d_f%h_err", i, f), {63'd0, err}, {63'd0, m_err});
            chk($sformatf("rnd%0d_f%h_lat", i, f), 64'(lat), 64'(m_lat));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
